// File: rtl/gift_masked_sbox_layer_ctrl.sv
// Nibble-serial sequencer for a 3-share masked GIFT S-box pipeline.
// Each share stays in its own register lane from input to result; the lanes
// are never combined here.
module gift_masked_sbox_layer_ctrl #(
    parameter int NIBBLES  = 16,
    parameter int SBOX_LAT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] state1,
    input  logic [4*NIBBLES-1:0] state2,
    input  logic [4*NIBBLES-1:0] state3,
    input  logic [7:0]           rnd_in,
    input  logic                 rnd_valid,
    output logic                 rnd_ready,
    output logic [3:0]           sb_in1,
    output logic [3:0]           sb_in2,
    output logic [3:0]           sb_in3,
    output logic [7:0]           sb_r,
    input  logic [3:0]           sb_out1,
    input  logic [3:0]           sb_out2,
    input  logic [3:0]           sb_out3,
    output logic [4*NIBBLES-1:0] res1,
    output logic [4*NIBBLES-1:0] res2,
    output logic [4*NIBBLES-1:0] res3,
    output logic                 busy,
    output logic                 done
);

    localparam int W     = 4 * NIBBLES;
    localparam int CNT_W = $clog2(NIBBLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN
    } state_e;

    state_e              state_q;
    logic                busy_q;
    logic                done_q;
    logic [W-1:0]        ld1_q, ld2_q, ld3_q;
    logic [W-1:0]        res1_q, res2_q, res3_q;
    logic [CNT_W-1:0]    issue_cnt_q;
    logic [CNT_W-1:0]    collect_cnt_q;
    logic [SBOX_LAT-1:0] vpipe_q;

    logic accept;
    logic issue;
    logic capture;
    logic issue_last;
    logic collect_last;

    // A start coinciding with the done pulse is deferred by one cycle.
    assign accept       = (state_q == IDLE) && start && !done_q;
    assign issue        = (state_q == FEED) && rnd_valid;
    // Oldest valid-pipe entry: the S-box output this cycle belongs to an issued nibble.
    assign capture      = vpipe_q[SBOX_LAT-1];
    assign issue_last   = (issue_cnt_q == CNT_W'(NIBBLES - 1));
    assign collect_last = (collect_cnt_q == CNT_W'(NIBBLES - 1));

    // Sequencing FSM with registered busy/done.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= FEED;
                        busy_q  <= 1'b1;
                    end
                end
                FEED: begin
                    if (issue && issue_last) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (capture && collect_last) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Load shift registers, counters, valid pipe and per-share result collection.
    // NOTE: the wide shift registers are reset as well, so no share material
    // from an aborted layer survives a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld1_q         <= '0;
            ld2_q         <= '0;
            ld3_q         <= '0;
            res1_q        <= '0;
            res2_q        <= '0;
            res3_q        <= '0;
            issue_cnt_q   <= '0;
            collect_cnt_q <= '0;
            vpipe_q       <= '0;
        end else begin
            vpipe_q <= (vpipe_q << 1) | SBOX_LAT'(issue);
            if (accept) begin
                ld1_q         <= state1;
                ld2_q         <= state2;
                ld3_q         <= state3;
                res1_q        <= '0;
                res2_q        <= '0;
                res3_q        <= '0;
                issue_cnt_q   <= '0;
                collect_cnt_q <= '0;
            end else begin
                if (issue) begin
                    ld1_q       <= {4'h0, ld1_q[W-1:4]};
                    ld2_q       <= {4'h0, ld2_q[W-1:4]};
                    ld3_q       <= {4'h0, ld3_q[W-1:4]};
                    issue_cnt_q <= issue_cnt_q + CNT_W'(1);
                end
                if (capture) begin
                    res1_q        <= {sb_out1, res1_q[W-1:4]};
                    res2_q        <= {sb_out2, res2_q[W-1:4]};
                    res3_q        <= {sb_out3, res3_q[W-1:4]};
                    collect_cnt_q <= collect_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // S-box feed: the current low nibble of each share on issue, zero bubble otherwise.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        rnd_ready = (state_q == FEED);
        sb_in1    = 4'h0;
        sb_in2    = 4'h0;
        sb_in3    = 4'h0;
        sb_r      = 8'h00;
        if (issue) begin
            sb_in1 = ld1_q[3:0];
            sb_in2 = ld2_q[3:0];
            sb_in3 = ld3_q[3:0];
            sb_r   = rnd_in;
        end
    end

    assign res1 = res1_q;
    assign res2 = res2_q;
    assign res3 = res3_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_gift_masked_sbox_layer_ctrl.sv
// Bench for gift_masked_sbox_layer_ctrl: a behavioural 3-share S-box with
// fixed latency sits downstream, and each layer's expected shares are derived
// from the GIFT S-box table and the randomness the bench itself supplied.
module tb_gift_masked_sbox_layer_ctrl;

    localparam int NIB = 16;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] state1, state2, state3;
    logic [7:0]  rnd_in;
    logic        rnd_valid;
    logic        rnd_ready;
    logic [3:0]  sb_in1, sb_in2, sb_in3;
    logic [7:0]  sb_r;
    logic [3:0]  sb_out1, sb_out2, sb_out3;
    logic [63:0] res1, res2, res3;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gift_masked_sbox_layer_ctrl #(
        .NIBBLES  (NIB),
        .SBOX_LAT (LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .state1    (state1),
        .state2    (state2),
        .state3    (state3),
        .rnd_in    (rnd_in),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .sb_in1    (sb_in1),
        .sb_in2    (sb_in2),
        .sb_in3    (sb_in3),
        .sb_r      (sb_r),
        .sb_out1   (sb_out1),
        .sb_out2   (sb_out2),
        .sb_out3   (sb_out3),
        .res1      (res1),
        .res2      (res2),
        .res3      (res3),
        .busy      (busy),
        .done      (done)
    );

    function automatic logic [3:0] gift_s(input logic [3:0] x);
        case (x)
            4'h0: return 4'h1;  4'h1: return 4'hA;  4'h2: return 4'h4;  4'h3: return 4'hC;
            4'h4: return 4'h6;  4'h5: return 4'hF;  4'h6: return 4'h3;  4'h7: return 4'h9;
            4'h8: return 4'h2;  4'h9: return 4'hD;  4'hA: return 4'hB;  4'hB: return 4'h7;
            4'hC: return 4'h5;  4'hD: return 4'h0;  4'hE: return 4'h8;  default: return 4'hE;
        endcase
    endfunction

    function automatic logic [63:0] gift_sub(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int k = 0; k < NIB; k++) y[4*k +: 4] = gift_s(x[4*k +: 4]);
        return y;
    endfunction

    // Masked S-box stand-in: output shares {r_hi, r_lo, S(x)^r_lo^r_hi}.
    function automatic logic [11:0] sbox_shares(input logic [3:0] a, b, c, input logic [7:0] r);
        return {r[7:4], r[3:0], gift_s(a ^ b ^ c) ^ r[3:0] ^ r[7:4]};
    endfunction

    logic [11:0] sbm_q [LAT] = '{default: '0};
    always @(posedge clk) begin
        sbm_q[0] <= sbox_shares(sb_in1, sb_in2, sb_in3, sb_r);
        for (int i = 1; i < LAT; i++) sbm_q[i] <= sbm_q[i-1];
    end
    assign {sb_out3, sb_out2, sb_out1} = sbm_q[LAT-1];

    // One full layer: start, per-cycle feed checks, done timing, result shares.
    task automatic run_layer(input string name, input logic [63:0] s1, s2, s3,
                             input logic [63:0] exp_xor, input logic [31:0] stall_mask,
                             input bit rand_rnd, input int start_cyc, input int abort_cyc,
                             input bit start_on_done);
        logic [63:0] exp1, exp2, exp3;
        logic [20:0] exp_port, got_port;
        logic [7:0]  r;
        logic        v, feed;
        int          n, stalls, ready_cnt, done_c;
        n = 0; stalls = 0; ready_cnt = 0; done_c = -1;
        exp2 = '0; exp3 = '0;
        state1 = s1; state2 = s2; state3 = s3;
        start = 1'b1; rnd_valid = 1'b0; rnd_in = 8'h00;
        @(posedge clk); #1;
        start  = 1'b0;
        state1 = {$urandom, $urandom};
        state2 = {$urandom, $urandom};
        state3 = {$urandom, $urandom};
        for (int c = 1; c <= 60; c++) begin
            feed      = (n < NIB);
            v         = (c < 32) ? !stall_mask[c] : 1'b1;
            r         = rand_rnd ? 8'($urandom) : 8'h00;
            rnd_valid = v;
            rnd_in    = r;
            start     = (c == start_cyc);
            if (c == abort_cyc) begin
                rst_n = 1'b0;
                #1;
                n_checks++;
                if ({busy, done, rnd_ready, sb_in1, sb_in2, sb_in3, sb_r, res1, res2, res3} !== '0) begin
                    n_fail++;
                    $display("FAIL %s reset_outputs: busy=%b done=%b ready=%b sb_in=%h%h%h sb_r=%h res1=%h res2=%h res3=%h, required all 0",
                             name, busy, done, rnd_ready, sb_in3, sb_in2, sb_in1, sb_r, res1, res2, res3);
                end
                repeat (3) begin
                    @(negedge clk);
                    n_checks++;
                    if (done !== 1'b0 || busy !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s held_in_reset: done=%b busy=%b, required 0 0", name, done, busy);
                    end
                end
                @(posedge clk); #1;
                rst_n = 1'b1; rnd_valid = 1'b0; start = 1'b0;
                return;
            end
            @(negedge clk);
            if (c == 1) begin
                n_checks++;
                if ({res1, res2, res3} !== '0) begin
                    n_fail++;
                    $display("FAIL %s res_cleared_at_start: res1=%h res2=%h res3=%h, required 0", name, res1, res2, res3);
                end
            end
            if (feed && v) begin
                exp_port        = {1'b1, s3[4*n +: 4], s2[4*n +: 4], s1[4*n +: 4], r};
                exp2[4*n +: 4]  = r[3:0];
                exp3[4*n +: 4]  = r[7:4];
                n++;
            end else begin
                exp_port = {feed, 20'h0};
                if (feed) stalls++;
            end
            got_port = {rnd_ready, sb_in3, sb_in2, sb_in1, sb_r};
            n_checks++;
            if (got_port !== exp_port) begin
                n_fail++;
                $display("FAIL %s feed_port cycle %0d: {ready,sb_in3,sb_in2,sb_in1,sb_r}=%h, required %h", name, c, got_port, exp_port);
            end
            if (rnd_ready === 1'b1) ready_cnt++;
            n_checks++;
            if (busy !== (done === 1'b1 ? 1'b0 : 1'b1)) begin
                n_fail++;
                $display("FAIL %s busy cycle %0d: busy=%b done=%b", name, c, busy, done);
            end
            if (done === 1'b1) begin
                done_c = c;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; rnd_valid = 1'b0;
        exp1 = exp_xor ^ exp2 ^ exp3;
        n_checks++;
        if (done_c - 1 != 20 + stalls) begin
            n_fail++;
            $display("FAIL %s done_latency: %0d cycles after start (-2 = never), required %0d", name, done_c - 1, 20 + stalls);
        end
        n_checks++;
        if ((res1 ^ res2 ^ res3) !== exp_xor) begin
            n_fail++;
            $display("FAIL %s res_xor: %h, required %h", name, res1 ^ res2 ^ res3, exp_xor);
        end
        n_checks++;
        if (res1 !== exp1 || res2 !== exp2 || res3 !== exp3) begin
            n_fail++;
            $display("FAIL %s res_shares: %h %h %h, required %h %h %h", name, res1, res2, res3, exp1, exp2, exp3);
        end
        n_checks++;
        if (ready_cnt != NIB + stalls) begin
            n_fail++;
            $display("FAIL %s rnd_ready_cycles: %0d, required %0d", name, ready_cnt, NIB + stalls);
        end
        if (start_on_done) start = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_done: done=%b busy=%b, required 0 0", name, done, busy);
        end
        n_checks++;
        if (res1 !== exp1) begin
            n_fail++;
            $display("FAIL %s res_hold: res1=%h, required %h", name, res1, exp1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; rnd_valid = 1'b0; rnd_in = 8'h00;
        state1 = '0; state2 = '0; state3 = '0;
        #12;
        n_checks++;
        if ({busy, done, rnd_ready, sb_in1, sb_in2, sb_in3, sb_r, res1, res2, res3} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b ready=%b sb_r=%h res1=%h, required all 0", busy, done, rnd_ready, sb_r, res1);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || rnd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b ready=%b, required 0 0", busy, rnd_ready);
        end
    endtask

    task automatic test_no_stall();
        run_layer("no_stall", 64'h0123456789ABCDEF, '0, '0, 64'h1A4C6F392DB7508E, '0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_random_shares();
        logic [63:0] s2, s3;
        for (int i = 0; i < 2; i++) begin
            s2 = {$urandom, $urandom};
            s3 = {$urandom, $urandom};
            run_layer("random_shares", 64'h0123456789ABCDEF ^ s2 ^ s3, s2, s3, 64'h1A4C6F392DB7508E, '0, 1'b1, 0, 0, 1'b0);
        end
    endtask

    task automatic test_stalls();
        logic [31:0] m;
        m = '0; m[3] = 1'b1; m[4] = 1'b1; m[9] = 1'b1;
        run_layer("stalls", 64'h0123456789ABCDEF, '0, '0, 64'h1A4C6F392DB7508E, m, 1'b1, 0, 0, 1'b0);
    endtask

    task automatic test_start_ignored();
        logic [63:0] a, b, c;
        run_layer("start_during_feed", 64'hFEDCBA9876543210, 64'h0F0F0F0F0F0F0F0F, '0,
                  gift_sub(64'hFEDCBA9876543210 ^ 64'h0F0F0F0F0F0F0F0F), '0, 1'b1, 5, 0, 1'b1);
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom};
        run_layer("second_layer", a, b, c, gift_sub(a ^ b ^ c), '0, 1'b1, 0, 0, 1'b0);
    endtask

    task automatic test_reset_mid_drain();
        run_layer("reset_mid_drain", 64'h0123456789ABCDEF, '0, '0, 64'h1A4C6F392DB7508E, '0, 1'b1, 0, 19, 1'b0);
        run_layer("after_reset", 64'h0123456789ABCDEF, 64'h5555AAAA5555AAAA, 64'h5555AAAA5555AAAA,
                  64'h1A4C6F392DB7508E, '0, 1'b1, 0, 0, 1'b0);
    endtask

    task automatic test_all_zero();
        run_layer("all_zero", '0, '0, '0, 64'h1111111111111111, '0, 1'b1, 0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [63:0] a, b, c;
        for (int i = 0; i < 4; i++) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom};
            run_layer("back_to_back", a, b, c, gift_sub(a ^ b ^ c), $urandom & $urandom, 1'b1, 0, 0, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_no_stall();
        test_random_shares();
        test_stalls();
        test_start_ignored();
        test_reset_mid_drain();
        test_all_zero();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
